// File: rtl/cnoc_msg_assembler.sv
// Store-and-forward message buffer for CNOC request beats.
// Beats of a message are held back until its last beat has arrived and are
// then released together. A message longer than the buffer falls back to
// cut-through forwarding and raises a sticky oversize flag.
module cnoc_msg_assembler #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN_beat,
   input  logic [31:0]      beat,
   output logic             RDY_beat,
   input  logic             EN_deq,
   output logic [31:0]      first,
   output logic             RDY_deq,
   output logic [CNT_W-1:0] msg_count,
   output logic             err_oversize
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam logic [OW-1:0] FULL = OW'(DEPTH);

   localparam logic [1:0] ST_HDR  = 2'd0;
   localparam logic [1:0] ST_BODY = 2'd1;
   localparam logic [1:0] ST_PASS = 2'd2;

   logic [31:0]    mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [OW-1:0]  count;
   logic [OW-1:0]  committed;
   logic [OW-1:0]  pending;
   logic [15:0]    remaining;
   logic [1:0]     state;

   logic [OW-1:0]  count_n;
   logic [OW-1:0]  committed_n;
   logic [OW-1:0]  pending_n;
   logic [OW-1:0]  commit_amt;
   logic [15:0]    remaining_n;
   logic [1:0]     state_n;
   logic           msg_inc;

   logic           wr_fire;
   logic           rd_fire;
   logic           oversize_evt;
   logic [15:0]    hdr_rem;

   assign RDY_beat     = !RST && (count < FULL);
   assign RDY_deq      = !RST && (committed != '0);
   assign wr_fire      = EN_beat && RDY_beat;
   assign rd_fire      = EN_deq && RDY_deq;
   assign first        = mem[rd_ptr];
   assign hdr_rem      = (beat[15:0] == 16'd0) ? 16'd0 : (beat[15:0] - 16'd1);
   assign oversize_evt = (count == FULL) && (committed == '0);

   // Message framing and commit accounting: decides how many buffered beats become visible downstream this cycle
   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      pending_n   = pending;
      commit_amt  = '0;
      msg_inc     = 1'b0;
      if (oversize_evt) begin
         commit_amt = pending;
         pending_n  = '0;
         state_n    = ST_PASS;
      end else if (wr_fire) begin
         case (state)
            ST_HDR: begin
               if (hdr_rem == 16'd0) begin
                  commit_amt = pending + OW'(1);
                  pending_n  = '0;
                  msg_inc    = 1'b1;
               end else begin
                  remaining_n = hdr_rem;
                  pending_n   = pending + OW'(1);
                  state_n     = ST_BODY;
               end
            end
            ST_BODY: begin
               remaining_n = remaining - 16'd1;
               if (remaining == 16'd1) begin
                  commit_amt = pending + OW'(1);
                  pending_n  = '0;
                  msg_inc    = 1'b1;
                  state_n    = ST_HDR;
               end else begin
                  pending_n = pending + OW'(1);
               end
            end
            ST_PASS: begin
               commit_amt  = OW'(1);
               remaining_n = remaining - 16'd1;
               if (remaining == 16'd1) begin
                  msg_inc = 1'b1;
                  state_n = ST_HDR;
               end
            end
            default: begin
               state_n = ST_HDR;
            end
         endcase
      end
      committed_n = committed + commit_amt - OW'(rd_fire);
      count_n     = count + OW'(wr_fire) - OW'(rd_fire);
   end

   // Registered control state; reset drops any message in flight, committed or not
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         committed    <= '0;
         pending      <= '0;
         remaining    <= '0;
         state        <= ST_HDR;
         msg_count    <= '0;
         err_oversize <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count     <= count_n;
         committed <= committed_n;
         pending   <= pending_n;
         remaining <= remaining_n;
         state     <= state_n;
         if (msg_inc) begin
            msg_count <= msg_count + CNT_W'(1);
         end
         if (oversize_evt) begin
            err_oversize <= 1'b1;
         end
      end
   end

   // Beat storage; contents need no reset because occupancy gates every read
   always_ff @(posedge CLK) begin
      if (wr_fire) begin
         mem[wr_ptr] <= beat;
      end
   end

endmodule
